bus_arbiter_2m1s: RTL and testbench

- Shares one slave bus port between two masters: m0 = core instruction fetch (ibus), m1 = core load/store (dbus).
- Lets a single-ported SRAM or peripheral crossbar serve both core buses.
- Round-robin arbitration with one transaction granted at a time.
- Captures request fields at grant and holds them stable on the slave port.
- Optional watchdog terminates hung slave transactions with an error.

---
 rtl/bus_if_types_pkg.sv | 24 ++
 rtl/bus_arbiter_2m1s_if.sv | 23 ++
 rtl/rr_pick2.sv | 17 +
 rtl/bus_arbiter_2m1s.sv | 113 +++++++++++
 tb/tb_bus_arbiter_2m1s.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/bus_if_types_pkg.sv
// rtl/bus_if_types_pkg.sv - shared core-bus transaction types and arbiter constants
// Contents: ttype_e (READ/WRITE), tsize_e (BYTE/HALF/WORD), arb_state_e, ARB_DEFAULT_TIMEOUT.
package bus_if_types_pkg;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } ttype_e;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } tsize_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } arb_state_e;

  localparam int ARB_DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/bus_arbiter_2m1s_if.sv
// rtl/bus_arbiter_2m1s_if.sv - one core-bus port: request fields plus completion response
// Signals: bstart/ttype/tsize/addr/wdata flow initiator->target;
//          rdata/bdone/err flow target->initiator.
// Modports: master = initiator side, slave = target side.
interface bus_arbiter_2m1s_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  import bus_if_types_pkg::*;

  logic              bstart;
  ttype_e            ttype;
  tsize_e            tsize;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              bdone;
  logic              err;

  modport master (output bstart, ttype, tsize, addr, wdata, input rdata, bdone, err);
  modport slave  (input bstart, ttype, tsize, addr, wdata, output rdata, bdone, err);

endinterface

// File: rtl/rr_pick2.sv
// rtl/rr_pick2.sv - combinational two-way round-robin chooser
// Ports: req[1:0] requesters, last = index of previous winner, win[1:0] one-hot winner.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] win
);

  always_comb begin
    win = req;
    // On a tie the master that did not win last time goes first.
    if (req == 2'b11) begin
      win = last ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/bus_arbiter_2m1s.sv
// rtl/bus_arbiter_2m1s.sv - round-robin arbiter sharing one slave bus between ibus (m0) and dbus (m1)
// Ports: clk, rst (sync, active-high); m0/m1 = master buses (target side here);
//        s = slave bus (initiator side here); gnt = one-hot current owner, 00 when idle.
// TIMEOUT = slave response limit in cycles, 0 disables the watchdog.
module bus_arbiter_2m1s #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = bus_if_types_pkg::ARB_DEFAULT_TIMEOUT
) (
  input  logic                clk,
  input  logic                rst,
  bus_arbiter_2m1s_if.slave   m0,
  bus_arbiter_2m1s_if.slave   m1,
  bus_arbiter_2m1s_if.master  s,
  output logic [1:0]          gnt
);
  import bus_if_types_pkg::*;

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  arb_state_e        state;
  logic              last;
  logic [1:0]        gnt_q;
  logic              s_bstart_q;
  ttype_e            cap_ttype;
  tsize_e            cap_tsize;
  logic [ADDR_W-1:0] cap_addr;
  logic [DATA_W-1:0] cap_wdata;
  logic [CNT_W-1:0]  cnt;

  logic [1:0] req;
  logic [1:0] win;
  logic       busy;
  logic       timeout_hit;
  logic       ok_fire;
  logic       resp_fire;

  assign req = {m1.bstart, m0.bstart};

  rr_pick2 u_pick (
    .req  (req),
    .last (last),
    .win  (win)
  );

  // Responses are suppressed while rst is high so an aborted transaction never completes.
  assign busy        = (state == BUSY) && !rst;
  assign ok_fire     = busy && s.bdone;
  assign timeout_hit = (TIMEOUT != 0) && busy && (cnt == CNT_LAST) && !s.bdone;
  assign resp_fire   = ok_fire || timeout_hit;

  assign m0.bdone = resp_fire && gnt_q[0];
  assign m0.err   = timeout_hit && gnt_q[0];
  assign m0.rdata = (ok_fire && gnt_q[0]) ? s.rdata : '0;
  assign m1.bdone = resp_fire && gnt_q[1];
  assign m1.err   = timeout_hit && gnt_q[1];
  assign m1.rdata = (ok_fire && gnt_q[1]) ? s.rdata : '0;

  assign s.bstart = s_bstart_q;
  assign s.ttype  = cap_ttype;
  assign s.tsize  = cap_tsize;
  assign s.addr   = cap_addr;
  assign s.wdata  = cap_wdata;
  assign gnt      = gnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last       <= 1'b1;
      gnt_q      <= 2'b00;
      s_bstart_q <= 1'b0;
      cap_ttype  <= READ;
      cap_tsize  <= BYTE;
      cap_addr   <= '0;
      cap_wdata  <= '0;
      cnt        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|win) begin
            cap_ttype  <= win[1] ? m1.ttype : m0.ttype;
            cap_tsize  <= win[1] ? m1.tsize : m0.tsize;
            cap_addr   <= win[1] ? m1.addr  : m0.addr;
            cap_wdata  <= win[1] ? m1.wdata : m0.wdata;
            gnt_q      <= win;
            last       <= win[1];
            s_bstart_q <= 1'b1;
            state      <= BUSY;
          end
        end
        BUSY: begin
          if (resp_fire) begin
            gnt_q      <= 2'b00;
            s_bstart_q <= 1'b0;
            cnt        <= '0;
            state      <= DONE;
          end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          // Dead cycle gives the finished master time to drop bstart.
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter_2m1s.sv
// tb/tb_bus_arbiter_2m1s.sv - directed self-checking bench for bus_arbiter_2m1s
module tb_bus_arbiter_2m1s;
  import bus_if_types_pkg::*;

  logic       clk;
  logic       rst;
  logic [1:0] gnt;
  int         n_checks;
  int         n_errors;

  bus_arbiter_2m1s_if #(.ADDR_W(32), .DATA_W(32)) m0_bus ();
  bus_arbiter_2m1s_if #(.ADDR_W(32), .DATA_W(32)) m1_bus ();
  bus_arbiter_2m1s_if #(.ADDR_W(32), .DATA_W(32)) s_bus ();

  bus_arbiter_2m1s #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
    .clk (clk),
    .rst (rst),
    .m0  (m0_bus),
    .m1  (m1_bus),
    .s   (s_bus),
    .gnt (gnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: got still-running expected finished");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] req_word(ttype_e t, tsize_e z, logic [31:0] a, logic [31:0] d);
    return {61'b0, t, z, a, d};
  endfunction

  function automatic logic [127:0] s_req();
    return {61'b0, s_bus.ttype, s_bus.tsize, s_bus.addr, s_bus.wdata};
  endfunction

  // Called in an IDLE cycle with requests driven; slave answers lat cycles after s_bstart.
  task automatic serve(input string tag, input int lat, input logic [31:0] rd,
                       input logic [1:0] exp_gnt, input logic [127:0] exp_req);
    tick();
    chk({tag, ".gnt"}, gnt, exp_gnt);
    chk({tag, ".bstart"}, s_bus.bstart, 1);
    chk({tag, ".req"}, s_req(), exp_req);
    repeat (lat) tick();
    s_bus.bdone = 1'b1;
    s_bus.rdata = rd;
    #1;
    chk({tag, ".bdone"}, {m1_bus.bdone, m0_bus.bdone}, exp_gnt);
    chk({tag, ".rdata"}, exp_gnt[0] ? m0_bus.rdata : m1_bus.rdata, rd);
    chk({tag, ".err"}, {m1_bus.err, m0_bus.err}, 0);
    chk({tag, ".other_rdata"}, exp_gnt[0] ? m1_bus.rdata : m0_bus.rdata, 0);
    tick();
    s_bus.bdone = 1'b0;
    s_bus.rdata = '0;
    #1;
    chk({tag, ".done"}, {s_bus.bstart, gnt, m1_bus.bdone, m0_bus.bdone}, 0);
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b0;
    m0_bus.bstart = 0; m0_bus.ttype = READ; m0_bus.tsize = BYTE; m0_bus.addr = '0; m0_bus.wdata = '0;
    m1_bus.bstart = 0; m1_bus.ttype = READ; m1_bus.tsize = BYTE; m1_bus.addr = '0; m1_bus.wdata = '0;
    s_bus.rdata = '0; s_bus.bdone = 1'b0; s_bus.err = 1'b0;

    do_reset();
    chk("reset.outs", {s_bus.bstart, gnt, m1_bus.bdone, m0_bus.bdone, m1_bus.err, m0_bus.err}, 0);
    chk("reset.rdata", {m1_bus.rdata, m0_bus.rdata}, 0);
    chk("reset.fields", s_req(), 0);

    // Single m0 read
    m0_bus.ttype = READ; m0_bus.tsize = WORD; m0_bus.addr = 32'h0000_0010; m0_bus.bstart = 1;
    #1;
    chk("single.latency", gnt, 0);
    serve("single", 2, 32'hDEAD_BEEF, 2'b01, req_word(READ, WORD, 32'h10, 32'h0));
    m0_bus.bstart = 0;

    // Tie from reset, then alternation
    do_reset();
    m0_bus.ttype = READ;  m0_bus.tsize = WORD; m0_bus.addr = 32'h100; m0_bus.wdata = 32'h0; m0_bus.bstart = 1;
    m1_bus.ttype = WRITE; m1_bus.tsize = HALF; m1_bus.addr = 32'h204; m1_bus.wdata = 32'h1234; m1_bus.bstart = 1;
    serve("tie0", 2, 32'h1111_1111, 2'b01, req_word(READ, WORD, 32'h100, 32'h0));
    serve("tie1", 2, 32'h2222_2222, 2'b10, req_word(WRITE, HALF, 32'h204, 32'h1234));
    serve("alt0", 1, 32'h3333_3333, 2'b01, req_word(READ, WORD, 32'h100, 32'h0));
    serve("alt1", 0, 32'h4444_4444, 2'b10, req_word(WRITE, HALF, 32'h204, 32'h1234));
    serve("alt2", 2, 32'h5555_5555, 2'b01, req_word(READ, WORD, 32'h100, 32'h0));
    m0_bus.bstart = 0;
    m1_bus.bstart = 0;

    // m1 changes addr and drops bstart mid-BUSY
    m1_bus.ttype = READ; m1_bus.tsize = WORD; m1_bus.addr = 32'h300; m1_bus.bstart = 1;
    tick();
    chk("hold.gnt", gnt, 2'b10);
    chk("hold.addr0", s_bus.addr, 32'h300);
    m1_bus.addr = 32'hFFFF_FFFC;
    m1_bus.bstart = 0;
    tick();
    chk("hold.addr1", s_bus.addr, 32'h300);
    chk("hold.bstart", s_bus.bstart, 1);
    s_bus.bdone = 1; s_bus.rdata = 32'h0000_55AA;
    #1;
    chk("hold.bdone", {m1_bus.bdone, m0_bus.bdone}, 2'b10);
    chk("hold.rdata", m1_bus.rdata, 32'h0000_55AA);
    tick();
    s_bus.bdone = 0; s_bus.rdata = '0;
    #1;
    chk("hold.addr_done", s_bus.addr, 32'h300);
    chk("hold.done_bstart", s_bus.bstart, 0);
    tick();

    // Watchdog timeout (TIMEOUT=4)
    m0_bus.ttype = READ; m0_bus.tsize = WORD; m0_bus.addr = 32'h400; m0_bus.bstart = 1;
    s_bus.rdata = 32'hAAAA_5555;
    tick();
    chk("to.gnt", gnt, 2'b01);
    tick();
    tick();
    chk("to.early", {m1_bus.bdone, m0_bus.bdone}, 0);
    tick();
    chk("to.bdone", {m1_bus.bdone, m0_bus.bdone}, 2'b01);
    chk("to.err", {m1_bus.err, m0_bus.err}, 2'b01);
    chk("to.rdata", m0_bus.rdata, 0);
    m0_bus.bstart = 0;
    tick();
    chk("to.after", {s_bus.bstart, gnt, m0_bus.bdone}, 0);
    tick();
    s_bus.rdata = '0;
    m1_bus.ttype = WRITE; m1_bus.tsize = WORD; m1_bus.addr = 32'h500; m1_bus.wdata = 32'h0BAD_F00D; m1_bus.bstart = 1;
    serve("post_to", 2, 32'h1234_5678, 2'b10, req_word(WRITE, WORD, 32'h500, 32'h0BAD_F00D));
    m1_bus.bstart = 0;

    // s_bdone in the same cycle as the timeout
    m0_bus.bstart = 1;
    tick();
    tick();
    tick();
    tick();
    s_bus.bdone = 1; s_bus.rdata = 32'hCAFE_F00D;
    #1;
    chk("coinc.bdone", m0_bus.bdone, 1);
    chk("coinc.err", m0_bus.err, 0);
    chk("coinc.rdata", m0_bus.rdata, 32'hCAFE_F00D);
    m0_bus.bstart = 0;
    tick();
    s_bus.bdone = 0; s_bus.rdata = '0;
    tick();

    // Stray s_bdone while idle
    s_bus.bdone = 1; s_bus.rdata = 32'h1;
    #1;
    chk("stray.outs", {m1_bus.bdone, m0_bus.bdone, m1_bus.rdata, m0_bus.rdata, s_bus.bstart, gnt}, 0);
    tick();
    s_bus.bdone = 0; s_bus.rdata = '0;
    #1;
    chk("stray.idle", {s_bus.bstart, gnt}, 0);

    // Reset mid-BUSY with both requesting (last=m0, so m1 is granted first)
    m0_bus.bstart = 1;
    m1_bus.bstart = 1;
    tick();
    chk("rst.gnt", gnt, 2'b10);
    tick();
    rst = 1;
    #1;
    chk("rst.no_bdone", {m1_bus.bdone, m0_bus.bdone}, 0);
    tick();
    rst = 0;
    #1;
    chk("rst.outs", {s_bus.bstart, gnt, m1_bus.bdone, m0_bus.bdone}, 0);
    serve("rst.tie", 2, 32'h7777_0000, 2'b01, req_word(READ, WORD, 32'h400, 32'h0));
    m0_bus.bstart = 0;
    m1_bus.bstart = 0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
